sbio_bus_arb: RTL and testbench



---
 rtl/sbio_arb_pkg.sv | 17 +
 rtl/sbio_arb_pick.sv | 33 +++
 rtl/sbio_bus_arb.sv | 133 +++++++++++++
 tb/tb_sbio_bus_arb.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sbio_arb_pkg.sv
// rtl/sbio_arb_pkg.sv - shared state encoding, direction values and counter width for the SB_IO pad arbiter
package sbio_arb_pkg;

    localparam int CNT_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TURN,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DONE
    } arb_state_t;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

endpackage

// File: rtl/sbio_arb_pick.sv
// rtl/sbio_arb_pick.sv - two-input grant logic; round-robin when SBIO_ARB_RR_EN is defined, fixed priority otherwise
module sbio_arb_pick (
`ifdef SBIO_ARB_RR_EN
    input  logic clk,
    input  logic reset,
    input  logic take,
`endif
    input  logic req0,
    input  logic req1,
    output logic win,
    output logic valid
);

    assign valid = req0 | req1;

`ifdef SBIO_ARB_RR_EN
    // ptr_q names the requester that wins a tie; it moves away from each winner
    logic ptr_q;

    assign win = (req0 && req1) ? ptr_q : !req0;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else if (take && valid) begin
            ptr_q <= ~win;
        end
    end
`else
    assign win = !req0;
`endif

endmodule

// File: rtl/sbio_bus_arb.sv
// rtl/sbio_bus_arb.sv - shares one bidirectional SB_IO pad bank between two requesters with turnaround dead cycles
// Arbitration mode selected by SBIO_ARB_RR_EN (round-robin when defined, fixed priority otherwise).
module sbio_bus_arb
    import sbio_arb_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int TURN   = 1,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] rdata,
    output logic             pin_oe,
    output logic [WIDTH-1:0] pin_dout,
    input  logic [WIDTH-1:0] pin_din
);

    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN - 1);
    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    arb_state_t       state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             dir_q, dir_n;
    logic             win_q, win_n;
    logic             we_q, we_n;
    logic [WIDTH-1:0] wdata_q, wdata_n;
    logic             mask0_q, mask1_q;
    logic             pick_win, pick_valid;

    // A requester acked last cycle still shows its old req for one cycle
    sbio_arb_pick u_pick (
`ifdef SBIO_ARB_RR_EN
        .clk   (clk),
        .reset (reset),
        .take  (state_q == ST_IDLE),
`endif
        .req0  (req0 & ~mask0_q),
        .req1  (req1 & ~mask1_q),
        .win   (pick_win),
        .valid (pick_valid)
    );

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        dir_n   = dir_q;
        win_n   = win_q;
        we_n    = we_q;
        wdata_n = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    win_n   = pick_win;
                    we_n    = pick_win ? we1 : we0;
                    wdata_n = pick_win ? wdata1 : wdata0;
                    cnt_n   = '0;
                    if (we_n != dir_q) begin
                        dir_n   = we_n;
                        state_n = ST_TURN;
                    end else begin
                        state_n = (we_n == DIR_WR) ? ST_DRIVE : ST_SAMPLE;
                    end
                end
            end
            ST_TURN: begin
                if (cnt_q == TURN_LAST) begin
                    cnt_n   = '0;
                    state_n = (we_q == DIR_WR) ? ST_DRIVE : ST_SAMPLE;
                end else begin
                    cnt_n = cnt_q + CNT_ONE;
                end
            end
            ST_DRIVE: state_n = ST_IDLE;
            ST_SAMPLE: begin
                if (cnt_q == RD_LAST) begin
                    cnt_n   = '0;
                    state_n = ST_DONE;
                end else begin
                    cnt_n = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Pad and ack outputs are registered from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            dir_q    <= DIR_RD;
            win_q    <= 1'b0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            mask0_q  <= 1'b0;
            mask1_q  <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata    <= '0;
            pin_oe   <= 1'b0;
            pin_dout <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            dir_q   <= dir_n;
            win_q   <= win_n;
            we_q    <= we_n;
            wdata_q <= wdata_n;
            mask0_q <= ack0;
            mask1_q <= ack1;
            ack0    <= ((state_n == ST_DRIVE) || (state_n == ST_DONE)) && !win_n;
            ack1    <= ((state_n == ST_DRIVE) || (state_n == ST_DONE)) && win_n;
            pin_oe  <= (state_n == ST_DRIVE);
            if (state_n == ST_DRIVE) begin
                pin_dout <= wdata_n;
            end
            if ((state_q == ST_SAMPLE) && (cnt_q == RD_LAST)) begin
                rdata <= pin_din;
            end
        end
    end

endmodule

// File: tb/tb_sbio_bus_arb.sv
// tb/tb_sbio_bus_arb.sv - self-checking bench for sbio_bus_arb (TURN=1 and TURN=3 instances)
module tb_sbio_bus_arb;

    localparam int TURN_A = 1;
    localparam int RDL_A  = 1;
    localparam int TURN_B = 3;
    localparam int RDL_B  = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic       req0_a = 0, req1_a = 0, we0_a = 0, we1_a = 0;
    logic [7:0] wdata0_a = 0, wdata1_a = 0;
    logic       ack0_a, ack1_a, pin_oe_a;
    logic [7:0] rdata_a, pin_dout_a, pin_din_a;
    logic       ext_drv_a = 0, rd_open_a = 0;
    logic [7:0] ext_val_a = 0;
    logic [7:0] last_rd_m = 0;

    logic       req0_b = 0, req1_b = 0, we0_b = 0, we1_b = 0;
    logic [7:0] wdata0_b = 0, wdata1_b = 0;
    logic       ack0_b, ack1_b, pin_oe_b;
    logic [7:0] rdata_b, pin_dout_b, pin_din_b;
    logic       ext_drv_b = 0, rd_open_b = 0;
    logic [7:0] ext_val_b = 0;

    typedef struct {
        logic       sel;
        logic       rd;
        logic [7:0] data;
        int         exp_cyc;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic       sel;
        logic       we;
        logic [7:0] d;
        logic [7:0] pad;
        int         lat;
    } vec_t;
    vec_t tbl[7];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External device starts driving one cycle after the pads are released
    always @(posedge clk) begin
        ext_drv_a <= rd_open_a && !pin_oe_a;
        ext_drv_b <= rd_open_b && !pin_oe_b;
    end
    assign pin_din_a = ext_drv_a ? ext_val_a : 8'h00;
    assign pin_din_b = ext_drv_b ? ext_val_b : 8'h00;

    sbio_bus_arb #(.WIDTH(8), .TURN(TURN_A), .RD_LAT(RDL_A)) dut_a (
        .clk(clk), .reset(reset), .req0(req0_a), .req1(req1_a), .we0(we0_a), .we1(we1_a),
        .wdata0(wdata0_a), .wdata1(wdata1_a), .ack0(ack0_a), .ack1(ack1_a), .rdata(rdata_a),
        .pin_oe(pin_oe_a), .pin_dout(pin_dout_a), .pin_din(pin_din_a)
    );

    sbio_bus_arb #(.WIDTH(8), .TURN(TURN_B), .RD_LAT(RDL_B)) dut_b (
        .clk(clk), .reset(reset), .req0(req0_b), .req1(req1_b), .we0(we0_b), .we1(we1_b),
        .wdata0(wdata0_b), .wdata1(wdata1_b), .ack0(ack0_b), .ack1(ack1_b), .rdata(rdata_b),
        .pin_oe(pin_oe_b), .pin_dout(pin_dout_b), .pin_din(pin_din_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic sel, input logic rd, input logic [7:0] data, input int exp_cyc);
        sb_t e;
        e.sel = sel; e.rd = rd; e.data = data; e.exp_cyc = exp_cyc;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1; last_rd_m = 0; rd_open_a = 0; rd_open_b = 0;
        req0_a = 0; req1_a = 0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic wait_ack_a(input logic sel);
        bit got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = sel ? ack1_a : ack0_a;
        end
        chk("a_ack_seen", got, 1);
    endtask

    task automatic txn_a(input logic sel, input logic we, input logic [7:0] d,
                         input logic [7:0] pad, input int lat);
        @(posedge clk); #1;
        push(sel, !we, we ? d : pad, cyc + lat);
        ext_val_a = pad;
        rd_open_a = !we;
        if (sel) begin req1_a = 1; we1_a = we; wdata1_a = d; end
        else     begin req0_a = 1; we0_a = we; wdata0_a = d; end
        wait_ack_a(sel);
        @(posedge clk); #1;
        if (sel) req1_a = 0; else req0_a = 0;
        rd_open_a = 0;
    endtask

    task automatic txn_b(input logic we, input logic [7:0] d, input logic [7:0] pad, input int lat);
        int  start;
        bit  got = 0;
        @(posedge clk); #1;
        start = cyc;
        req1_b = 1; we1_b = we; wdata1_b = d; ext_val_b = pad; rd_open_b = !we;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = ack1_b;
        end
        chk("b_ack_seen", got, 1);
        if (got) begin
            chk("b_ack_lat", cyc - start, lat);
            chk("b_ack0_quiet", ack0_b, 0);
            if (we) chk("b_dout", pin_dout_b, d);
            else    chk("b_rdata", rdata_b, pad);
        end
        @(posedge clk); #1;
        req1_b = 0; rd_open_b = 0;
    endtask

    // Scoreboard and pad monitor for instance A
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("a_contention", pin_oe_a & ext_drv_a, 0);
                chk("a_one_ack", ack0_a & ack1_a, 0);
                if (ack0_a || ack1_a) begin
                    chk("a_sb_nonempty", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("a_ack_who", ack1_a, e.sel);
                        chk("a_ack_cycle", cyc, e.exp_cyc);
                        if (e.rd) begin
                            chk("a_rd_oe", pin_oe_a, 0);
                            chk("a_rdata", rdata_a, e.data);
                            last_rd_m = e.data;
                        end else begin
                            chk("a_wr_oe", pin_oe_a, 1);
                            chk("a_dout", pin_dout_a, e.data);
                            chk("a_rdata_hold", rdata_a, last_rd_m);
                        end
                    end
                end else begin
                    chk("a_oe_idle", pin_oe_a, 0);
                end
            end
        end
    end

    // Turnaround gap and contention monitor for instance B
    initial begin
        int low_run = 0;
        bit seen = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                low_run = 0;
            end else begin
                chk("b_contention", pin_oe_b & ext_drv_b, 0);
                if (pin_oe_b) begin
                    if (seen) chk("b_turn_gap", low_run >= TURN_B + RDL_B + 2, 1);
                    seen = 1;
                    low_run = 0;
                end else begin
                    low_run++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic first;
        int   n;
        logic a0, a1;

        tbl[0] = '{sel: 0, we: 1, d: 8'h3C, pad: 8'h00, lat: 1};
        tbl[1] = '{sel: 0, we: 0, d: 8'h00, pad: 8'h5A, lat: 4};
        tbl[2] = '{sel: 1, we: 0, d: 8'h00, pad: 8'hC3, lat: 3};
        tbl[3] = '{sel: 1, we: 1, d: 8'h00, pad: 8'h00, lat: 2};
        tbl[4] = '{sel: 1, we: 1, d: 8'hFF, pad: 8'h00, lat: 1};
        tbl[5] = '{sel: 0, we: 0, d: 8'h00, pad: 8'h81, lat: 4};
        tbl[6] = '{sel: 0, we: 1, d: 8'h7E, pad: 8'h00, lat: 2};

        // Write request present as reset releases: TURN first, DRIVE two cycles later
        req0_a = 1; we0_a = 1; wdata0_a = 8'hA5;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        push(0, 0, 8'hA5, cyc + 2);
        @(negedge clk);
        chk("rst_oe", pin_oe_a, 0);
        chk("rst_dout", pin_dout_a, 0);
        chk("rst_ack0", ack0_a, 0);
        chk("rst_ack1", ack1_a, 0);
        chk("rst_rdata", rdata_a, 0);
        @(negedge clk);
        chk("turn_oe", pin_oe_a, 0);
        wait_ack_a(0);
        @(posedge clk); #1 req0_a = 0;

        for (int i = 0; i < 7; i++) begin
            txn_a(tbl[i].sel, tbl[i].we, tbl[i].d, tbl[i].pad, tbl[i].lat);
        end

        // Simultaneous fresh writes; last grant went to requester 0
`ifdef SBIO_ARB_RR_EN
        first = 1'b1;
`else
        first = 1'b0;
`endif
        @(posedge clk); #1;
        req0_a = 1; we0_a = 1; wdata0_a = 8'h5C;
        req1_a = 1; we1_a = 1; wdata1_a = 8'hC5;
        push(first, 0, first ? 8'hC5 : 8'h5C, cyc + 1);
        push(!first, 0, first ? 8'h5C : 8'hC5, cyc + 3);
        for (int k = 0; k < 20 && (req0_a || req1_a); k++) begin
            @(negedge clk);
            a0 = ack0_a; a1 = ack1_a;
            @(posedge clk); #1;
            if (a0) req0_a = 0;
            if (a1) req1_a = 0;
        end
        chk("tie_done", {req0_a, req1_a}, 0);
        req0_a = 0; req1_a = 0;

        // Both requesters hold req: the just-acked one is skipped next IDLE
        do_reset();
        @(posedge clk); #1;
        req0_a = 1; we0_a = 1; wdata0_a = 8'h11;
        req1_a = 1; we1_a = 1; wdata1_a = 8'h22;
        push(0, 0, 8'h11, cyc + 2);
        push(1, 0, 8'h22, cyc + 4);
        push(0, 0, 8'h11, cyc + 6);
        push(1, 0, 8'h22, cyc + 8);
        n = 0;
        for (int k = 0; k < 40 && n < 4; k++) begin
            @(negedge clk);
            if (ack0_a || ack1_a) n++;
        end
        @(posedge clk); #1;
        req0_a = 0; req1_a = 0;
        chk("held_acks", n, 4);
        repeat (4) @(posedge clk);

        // Reset lands during SAMPLE: transaction abandoned
        do_reset();
        @(posedge clk); #1;
        req0_a = 1; we0_a = 0; ext_val_a = 8'h99; rd_open_a = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1; req0_a = 0; rd_open_a = 0;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("rs_oe", pin_oe_a, 0);
        chk("rs_ack", {ack0_a, ack1_a}, 0);
        chk("rs_rdata", rdata_a, 0);
        repeat (4) begin
            @(negedge clk);
            chk("rs_no_ack", {ack0_a, ack1_a}, 0);
        end

        // Requester drops req one cycle into a read
        @(posedge clk); #1;
        req0_a = 1; we0_a = 0; ext_val_a = 8'h6B; rd_open_a = 1;
        push(0, 1, 8'h6B, cyc + 3);
        @(posedge clk); #1;
        req0_a = 0;
        wait_ack_a(0);
        @(posedge clk); #1;
        rd_open_a = 0;
        repeat (3) begin
            @(negedge clk);
            chk("drop_single_ack", {ack0_a, ack1_a}, 0);
        end
        txn_a(1, 1, 8'h44, 8'h00, 2);

        // Wide turnaround instance: alternating write/read from requester 1
        txn_b(1, 8'hA1, 8'h00, 4);
        txn_b(0, 8'h00, 8'h3E, 6);
        txn_b(1, 8'hB2, 8'h00, 4);
        txn_b(0, 8'h00, 8'hE3, 6);

        repeat (5) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
